// File: rtl/ptr_sync_gray_level.sv
// Destination-domain half of an async FIFO pointer synchronizer: Gray sync chain,
// registered Gray-to-binary, fill level, full/empty flags and a sticky coherence error.
module ptr_sync_gray_level #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter bit MODE        = 1'b0
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [ADDR_W:0]   gray_ptr_in,
    input  logic [ADDR_W:0]   local_bin_ptr,
    input  logic              err_clr,
    output logic [ADDR_W:0]   gray_ptr_sync,
    output logic [ADDR_W:0]   bin_ptr_sync,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic              sync_valid,
    output logic              gray_err
);

    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int WARM  = SYNC_STAGES + 1;
    localparam int CW    = $clog2(WARM + 1);

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0]                  prev_q;
    logic [CW-1:0]                  warm_cnt;
    logic [PW-1:0]                  level_raw;
    logic                           err_set;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int i = PW - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic int unsigned popcnt(input logic [PW-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < PW; i++)
            c = c + int'(v[i]);
        return c;
    endfunction

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= gray_ptr_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign gray_ptr_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            bin_ptr_sync <= '0;
            prev_q       <= '0;
        end else begin
            bin_ptr_sync <= gray2bin(gray_ptr_sync);
            prev_q       <= gray_ptr_sync;
        end
    end

    // Modulo subtraction over the wrap-bit width absorbs pointer wrap.
    always_comb begin
        level_raw = '0;
        if (MODE)
            level_raw = bin_ptr_sync - local_bin_ptr;
        else
            level_raw = local_bin_ptr - bin_ptr_sync;
    end

    assign level      = level_raw;
    assign sync_valid = (warm_cnt == CW'(WARM));
    assign full       = !sync_valid || (level_raw == PW'(DEPTH));
    assign empty      = !sync_valid || (level_raw == '0);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            warm_cnt <= '0;
        else if (!sync_valid)
            warm_cnt <= warm_cnt + CW'(1);
    end

    // A legal Gray stream moves at most one bit per sample; level beyond DEPTH is impossible.
    assign err_set = sync_valid &&
                     ((popcnt(gray_ptr_sync ^ prev_q) > 1) || (level_raw > PW'(DEPTH)));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            gray_err <= 1'b0;
        else if (err_set)
            gray_err <= 1'b1;
        else if (err_clr)
            gray_err <= 1'b0;
    end

endmodule
